// File: rtl/wb_pipe_stage_if.sv
// MEM->WB bundle and handshake bus: slave is the stage's view, master the surrounding core.
// result_w is present only when WB_RESULT_MUX_EN is defined.
interface wb_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              valid_m;
  logic              ready_m;
  logic              regwrite_m;
  logic              memtoreg_m;
  logic [DATA_W-1:0] aluout_m;
  logic [DATA_W-1:0] readdata_m;
  logic [REG_AW-1:0] writereg_m;
  logic              flush;
  logic              valid_w;
  logic              ready_w;
  logic              regwrite_w;
  logic              memtoreg_w;
  logic [DATA_W-1:0] aluout_w;
  logic [DATA_W-1:0] readdata_w;
  logic [REG_AW-1:0] writereg_w;
  logic [1:0]        occ_w;
`ifdef WB_RESULT_MUX_EN
  logic [DATA_W-1:0] result_w;
`endif

  modport slave (
    input  valid_m, regwrite_m, memtoreg_m, aluout_m, readdata_m, writereg_m,
    input  flush, ready_w,
    output ready_m, valid_w, regwrite_w, memtoreg_w, aluout_w, readdata_w,
    output writereg_w, occ_w
`ifdef WB_RESULT_MUX_EN
    , output result_w
`endif
  );

  modport master (
    output valid_m, regwrite_m, memtoreg_m, aluout_m, readdata_m, writereg_m,
    output flush, ready_w,
    input  ready_m, valid_w, regwrite_w, memtoreg_w, aluout_w, readdata_w,
    input  writereg_w, occ_w
`ifdef WB_RESULT_MUX_EN
    , input result_w
`endif
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// Elastic MEM->WB stage: head + skid register, registered ready_m, synchronous flush.
// Optional in-stage writeback mux enabled by defining WB_RESULT_MUX_EN.
module wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic             clock,
  input  logic             reset,
  wb_pipe_stage_if.slave   bus
);
  localparam int BW = 2 + 2 * DATA_W + REG_AW;

  // State encoding equals the number of held bundles, so occ_w is the state itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ready_q, ready_d;
  logic [BW-1:0] head_q, head_d;
  logic [BW-1:0] skid_q, skid_d;

  logic          valid_w_int;
  logic          accept;
  logic          drain;
  logic [BW-1:0] in_bundle;

  logic              head_regwrite;
  logic              head_memtoreg;
  logic [DATA_W-1:0] head_aluout;
  logic [DATA_W-1:0] head_readdata;
  logic [REG_AW-1:0] head_writereg;

  assign in_bundle   = {bus.regwrite_m, bus.memtoreg_m, bus.aluout_m,
                        bus.readdata_m, bus.writereg_m};
  assign valid_w_int = (state_q != ST_EMPTY);
  assign accept      = bus.valid_m & ready_q;
  assign drain       = valid_w_int & bus.ready_w;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            head_d  = in_bundle;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            head_d = in_bundle;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_bundle;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // The skid entry is older than anything upstream, so it always moves to head first.
          if (drain) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign head_writereg = head_q[REG_AW-1:0];
  assign head_readdata = head_q[REG_AW +: DATA_W];
  assign head_aluout   = head_q[REG_AW + DATA_W +: DATA_W];
  assign head_memtoreg = head_q[BW-2];
  assign head_regwrite = head_q[BW-1];

  assign bus.ready_m    = ready_q;
  assign bus.valid_w    = valid_w_int;
  assign bus.occ_w      = state_q;
  assign bus.memtoreg_w = head_memtoreg;
  assign bus.aluout_w   = head_aluout;
  assign bus.readdata_w = head_readdata;
  assign bus.writereg_w = head_writereg;
  // Bubbles and writes to $0 must never reach the register file.
  assign bus.regwrite_w = head_regwrite & valid_w_int & (head_writereg != '0);

`ifdef WB_RESULT_MUX_EN
  assign bus.result_w = head_memtoreg ? head_readdata : head_aluout;
`endif
endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: expected bundles are queued at issue and a
// monitor compares them against every drained head bundle.
module tb_wb_pipe_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic          rw;
    logic          mt;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic [AW-1:0] wr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  wb_pipe_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  wb_pipe_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic drive(input logic rw, input logic mt, input logic [DW-1:0] alu,
                       input logic [DW-1:0] rd, input logic [AW-1:0] wr,
                       input logic exp_rw, input bit push);
    exp_t e;
    bus.valid_m    = 1'b1;
    bus.regwrite_m = rw;
    bus.memtoreg_m = mt;
    bus.aluout_m   = alu;
    bus.readdata_m = rd;
    bus.writereg_m = wr;
    if (push) begin
      e.rw = exp_rw; e.mt = mt; e.alu = alu; e.rd = rd; e.wr = wr;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    bus.valid_m    = 1'b0;
    bus.regwrite_m = 1'b0;
    bus.memtoreg_m = 1'b0;
    bus.aluout_m   = '0;
    bus.readdata_m = '0;
    bus.writereg_m = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid_w"},    32'(bus.valid_w),    32'd0);
    check({tag, "_regwrite_w"}, 32'(bus.regwrite_w), 32'd0);
    check({tag, "_memtoreg_w"}, 32'(bus.memtoreg_w), 32'd0);
    check({tag, "_aluout_w"},   bus.aluout_w,        32'd0);
    check({tag, "_readdata_w"}, bus.readdata_w,      32'd0);
    check({tag, "_writereg_w"}, 32'(bus.writereg_w), 32'd0);
    check({tag, "_occ_w"},      32'(bus.occ_w),      32'd0);
    check({tag, "_ready_m"},    32'(bus.ready_m),    32'd1);
`ifdef WB_RESULT_MUX_EN
    check({tag, "_result_w"},   bus.result_w,        32'd0);
`endif
  endtask

  // Monitor: a head bundle that will drain at the next rising edge is compared here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && bus.valid_w && bus.ready_w) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_drain", bus.aluout_w, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_aluout",   bus.aluout_w,        e.alu);
          check("sb_readdata", bus.readdata_w,      e.rd);
          check("sb_writereg", 32'(bus.writereg_w), 32'(e.wr));
          check("sb_memtoreg", 32'(bus.memtoreg_w), 32'(e.mt));
          check("sb_regwrite", 32'(bus.regwrite_w), 32'(e.rw));
        end
      end
    end
  end

  initial begin
    idle();
    bus.flush   = 1'b0;
    bus.ready_w = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_reset_vals("por");
    tick();
    reset = 1'b1;
    bus.ready_w = 1'b1;

    // Streaming: one bundle per cycle, occupancy stays at one.
    drive(1'b1, 1'b0, 32'd1, 32'h100, 5'd1, 1'b1, 1'b1);
    tick();
    for (int i = 2; i <= 9; i++) begin
      if (i <= 8) drive(1'b1, 1'b0, 32'(i), 32'(i) << 8, 5'(i), 1'b1, 1'b1);
      else idle();
      @(negedge clock);
      check($sformatf("stream_aluout_%0d", i - 1), bus.aluout_w, 32'(i - 1));
      check($sformatf("stream_occ_%0d", i - 1), 32'(bus.occ_w), 32'd1);
      tick();
    end
    @(negedge clock);
    check("stream_end_occ", 32'(bus.occ_w), 32'd0);

    // Backpressure: A (write to $0), B (write to $5), C (no write) held at input.
    tick();
    bus.ready_w = 1'b0;
    drive(1'b1, 1'b0, 32'hA, 32'hAA, 5'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'hB, 32'hBB, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'hC, 32'hCC, 5'd7, 1'b0, 1'b1);
    @(negedge clock);
    check("bp_occ_full", 32'(bus.occ_w), 32'd2);
    check("bp_ready_low", 32'(bus.ready_m), 32'd0);
    check("bp_head_A", bus.aluout_w, 32'hA);
    check("bp_reg0_suppressed", 32'(bus.regwrite_w), 32'd0);
    tick();
    @(negedge clock);
    check("bp_c_held_occ", 32'(bus.occ_w), 32'd2);
    check("bp_c_held_ready", 32'(bus.ready_m), 32'd0);
    tick();
    bus.ready_w = 1'b1;
    tick();
    @(negedge clock);
    check("bp_ready_back", 32'(bus.ready_m), 32'd1);
    check("bp_head_B", bus.aluout_w, 32'hB);
    check("bp_reg5_write", 32'(bus.regwrite_w), 32'd1);
    tick();
    idle();
    @(negedge clock);
    check("bp_head_C", bus.aluout_w, 32'hC);
    check("bp_occ_one", 32'(bus.occ_w), 32'd1);
    tick();
    @(negedge clock);
    check("bp_drained_occ", 32'(bus.occ_w), 32'd0);
    check("bubble_regwrite", 32'(bus.regwrite_w), 32'd0);

    // Flush in FULL with a bundle offered: everything held and offered is lost.
    tick();
    bus.ready_w = 1'b0;
    drive(1'b1, 1'b0, 32'hD, 32'h0, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hE, 32'h0, 5'd10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hF00D, 32'h0, 5'd11, 1'b1, 1'b0);
    @(negedge clock);
    check("fl_occ_full", 32'(bus.occ_w), 32'd2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    @(negedge clock);
    check("fl_valid_w", 32'(bus.valid_w), 32'd0);
    check("fl_occ", 32'(bus.occ_w), 32'd0);
    check("fl_ready_m", 32'(bus.ready_m), 32'd1);
    check("fl_regwrite", 32'(bus.regwrite_w), 32'd0);
    tick();
    @(negedge clock);
    check("fl_offer_lost", 32'(bus.occ_w), 32'd0);

    // Asynchronous reset with two bundles held.
    tick();
    drive(1'b1, 1'b1, 32'h1111, 32'h2222, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h3333, 32'h4444, 5'd4, 1'b1, 1'b0);
    tick();
    idle();
    @(negedge clock);
    check("rst_pre_occ", 32'(bus.occ_w), 32'd2);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    tick();
    reset = 1'b1;

    // First bundle after reset appears one cycle after acceptance.
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd3, 1'b1, 1'b1);
    tick();
    idle();
    @(negedge clock);
    check("lat_valid_w", 32'(bus.valid_w), 32'd1);
    check("lat_aluout", bus.aluout_w, 32'h0000_1234);
    check("lat_occ", 32'(bus.occ_w), 32'd1);
    tick();
    bus.ready_w = 1'b1;
    tick();
    @(negedge clock);
    check("lat_drained", 32'(bus.valid_w), 32'd0);

`ifdef WB_RESULT_MUX_EN
    tick();
    bus.ready_w = 1'b0;
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd2, 1'b1, 1'b1);
    tick();
    @(negedge clock);
    check("mux_readdata", bus.result_w, 32'hDEAD_BEEF);
    tick();
    bus.ready_w = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd2, 1'b1, 1'b1);
    tick();
    idle();
    @(negedge clock);
    check("mux_aluout", bus.result_w, 32'h10);
    tick();
    tick();
`endif

    check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
